// File: rtl/extend_arbiter_pkg.sv
// Shared types, widths and helpers for the extend_arbiter block.
package extend_arb_pkg;

    typedef enum logic {EMPTY, FULL} state_t;

    localparam int unsigned OPW    = 16;
    localparam int unsigned RESW   = 32;
    localparam int unsigned MAXREQ = 8;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } pick_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

    // First asserted request at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                      input int unsigned ptr,
                                      input int unsigned n);
        pick_t       p;
        int unsigned idx;
        p = '0;
        for (int unsigned i = 0; i < MAXREQ; i++) begin
            idx = (ptr + i) % n;
            if (i < n && !p.hit && req[idx[2:0]]) begin
                p.hit = 1'b1;
                p.idx = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/extend_arbiter_if.sv
// Requester and result handshake bundle for extend_arbiter.
interface extend_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = extend_arb_pkg::clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_a;
    logic [NREQ-1:0]    req_sext;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic [31:0]        resp_data;
    logic [IDW-1:0]     resp_id;
    logic               resp_ready;

    modport master (
        output req_valid, req_a, req_sext, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_sext, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/extend_arbiter_extend.sv
// 16 to 32-bit extension: sign-extend when sext=1, zero-extend otherwise.
module extend
    import extend_arb_pkg::*;
(
    input  logic [OPW-1:0]  a,
    input  logic            sext,
    output logic [RESW-1:0] b
);
    assign b = {{(RESW-OPW){sext & a[OPW-1]}}, a};
endmodule

// File: rtl/extend_arbiter.sv
// Round-robin arbiter sharing one extend datapath among NREQ requesters.
// Optional per-requester grant counters under EXTEND_ARBITER_STATS_EN.
module extend_arbiter
    import extend_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    extend_arbiter_if.slave bus
`ifdef EXTEND_ARBITER_STATS_EN
    ,
    output logic [16*NREQ-1:0] grant_cnt
`endif
);

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr, grant_idx;
    logic [MAXREQ-1:0] req_pad;
    pick_t             pick;
    logic              can_accept, take;
    logic [OPW-1:0]    sel_a;
    logic              sel_sext;
    logic [RESW-1:0]   ext_b;

    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = bus.req_valid;
        pick               = rr_pick(req_pad, 32'(rr_ptr), NREQ);
        grant_idx          = IDW'(pick.idx);
        can_accept         = !rst && (state == EMPTY || bus.resp_ready);
        take               = can_accept && pick.hit;
        sel_a              = bus.req_a[OPW*int'(grant_idx) +: OPW];
        sel_sext           = bus.req_sext[grant_idx];
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        if (take) begin
            bus.req_ready[grant_idx] = 1'b1;
            state_nxt                = FULL;
        end else if (state == FULL && bus.resp_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    extend u_extend (
        .a    (sel_a),
        .sext (sel_sext),
        .b    (ext_b)
    );

    // Data/id are only written on a grant, so a drain leaves them holding the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resp_data <= '0;
            bus.resp_id   <= '0;
            rr_ptr        <= '0;
        end else if (take) begin
            bus.resp_data <= ext_b;
            bus.resp_id   <= grant_idx;
            rr_ptr        <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign bus.resp_valid = (state == FULL);

`ifdef EXTEND_ARBITER_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (take && 32'(grant_idx) == i && cnt != '1)
                cnt <= cnt + 1'b1;
        end
        assign grant_cnt[16*i +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_extend_arbiter.sv
// Randomized and directed bench for extend_arbiter against a behavioural model.
module tb_extend_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    extend_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef EXTEND_ARBITER_STATS_EN
    logic [16*NREQ-1:0] grant_cnt;
`endif

    extend_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef EXTEND_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    bit              m_full = 1'b0;
    logic [31:0]     m_data = '0;
    int              m_id   = 0;
    int              m_ptr  = 0;
    logic [NREQ-1:0] acc_mask = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_w(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ext_model(input logic [15:0] a, input bit s);
        logic [31:0] r;
        r = 32'(a);
        if (s && a >= 16'h8000) r = r + 32'hFFFF_0000;
        return r;
    endfunction

    always @(posedge clk) begin
        int w;
        acc_mask <= '0;
        if (rst) begin
            m_full <= 1'b0;
            m_data <= '0;
            m_id   <= 0;
            m_ptr  <= 0;
        end else begin
            w = pick_w(bus.req_valid, m_ptr);
            if ((!m_full || bus.resp_ready) && w >= 0) begin
                m_data      <= ext_model(bus.req_a[16*w +: 16], bus.req_sext[w]);
                m_id        <= w;
                m_full      <= 1'b1;
                m_ptr       <= (w + 1) % NREQ;
                acc_mask[w] <= 1'b1;
            end else if (m_full && bus.resp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int w;
        if (cmp_en) begin
            er = '0;
            w  = pick_w(bus.req_valid, m_ptr);
            if (!rst && (!m_full || bus.resp_ready) && w >= 0) er[w] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_full));
            chk("resp_data", bus.resp_data, m_data);
            chk("resp_id", 32'(bus.resp_id), 32'(m_id));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] ma [4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h0000};
    bit          ms [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] me [4] = '{32'hFFFF8000, 32'h00008000, 32'h0000FFFF, 32'h00000000};

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_a      = '0;
        bus.req_sext   = '0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 cmp_en = 1'b1;

        // Reset with every requester asking
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", 32'(bus.req_ready), 32'h1);

        // Round-robin with all requesters held valid
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (k == 6) bus.req_valid = 4'b0100;
            @(negedge clk);
            chk("rr_id", 32'(bus.resp_id), 32'(k % 4));
            chk("rr_valid", 32'(bus.resp_valid), 32'h1);
        end
        chk("wrap_grant", 32'(bus.req_ready), 32'h4);
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("wrap_id", 32'(bus.resp_id), 32'h2);

        // Extension modes from requester 0
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.req_valid      = 4'b0001;
            bus.req_a[15:0]    = ma[k];
            bus.req_sext[0]    = ms[k];
            cyc();
            bus.req_valid = '0;
            @(negedge clk);
            chk("mode_data", bus.resp_data, me[k]);
            chk("mode_id", 32'(bus.resp_id), 32'h0);
        end

        // Drain to empty keeps last data
        cyc();
        bus.req_valid   = 4'b0001;
        bus.req_a[15:0] = 16'h1234;
        bus.req_sext[0] = 1'b0;
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("drain_full", 32'(bus.resp_valid), 32'h1);
        cyc();
        @(negedge clk);
        chk("drain_empty", 32'(bus.resp_valid), 32'h0);
        chk("drain_hold", bus.resp_data, 32'h00001234);

        // Back-pressure then simultaneous drain/accept
        cyc();
        bus.req_valid   = 4'b0001;
        bus.req_a[15:0] = 16'h0001;
        cyc();
        bus.req_valid    = 4'b0010;
        bus.req_a[31:16] = 16'hABCD;
        bus.req_sext[1]  = 1'b1;
        bus.resp_ready   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ready", 32'(bus.req_ready), 32'h0);
            chk("stall_data", bus.resp_data, 32'h00000001);
            cyc();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_grant", 32'(bus.req_ready), 32'h2);
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("bp_data", bus.resp_data, 32'hFFFFABCD);
        chk("bp_id", 32'(bus.resp_id), 32'h1);
        chk("bp_valid", 32'(bus.resp_valid), 32'h1);

        // Randomized traffic; ungranted requesters hold their request
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst            = ($urandom_range(0, 99) == 0);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || acc_mask[i]) begin
                    bus.req_valid[i]       = 1'($urandom_range(0, 1));
                    bus.req_a[16*i +: 16]  = 16'($urandom);
                    bus.req_sext[i]        = 1'($urandom_range(0, 1));
                end
            end
        end
        cyc();
        rst = 1'b0;

`ifdef EXTEND_ARBITER_STATS_EN
        cyc();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.req_valid = 4'b1000;
        repeat (5) cyc();
        @(negedge clk);
        chk("cnt3_early", 32'(grant_cnt[63:48]), 32'd5);
        repeat (70000) cyc();
        @(negedge clk);
        chk("cnt3_sat", 32'(grant_cnt[63:48]), 32'hFFFF);
        chk("cnt_others", 32'(grant_cnt[47:0] != '0), 32'h0);
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("cnt_rst", 32'(grant_cnt != '0), 32'h0);
        cyc();
        rst = 1'b0;
`endif

        cyc();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/extend_arbiter.md
Name: extend_arbiter

Overview:
- Shares one 16→32-bit extension datapath (a[15:0], sext, b[31:0]; sext=1 sign-extends, sext=0 zero-extends) among NREQ requesters.
- Round-robin arbitration, per-requester valid/ready input handshake, single registered result port with valid/ready.
- Sits between decode/immediate-generation clients and the downstream consumer of 32-bit operands.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of requester ID = clog2(NREQ); fixed by the package function, not user-set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  16*NREQ  operand; requester i uses bits [16*i+15:16*i].
- req_sext  in  NREQ  per-requester extension mode; 1 = sign, 0 = zero.
- req_ready  out  NREQ  one-hot grant/accept, combinational from state and pointer.
- resp_valid  out  1  result register holds valid data.
- resp_data  out  32  extended result.
- resp_id  out  IDW  index of the requester that produced resp_data.
- resp_ready  in  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, rst. Sampled only on the rising edge of clk.
- Reset values: resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0, FSM=EMPTY.
  - req_ready is 0 while rst=1.
- FSM states:
  - EMPTY: result register free.
  - FULL: result held awaiting resp_ready.
- Accept condition: can_accept = (state==EMPTY) | (state==FULL & resp_ready).
  - Gives full throughput: one result per cycle when resp_ready stays 1.
- Arbitration (combinational):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NREQ. The first asserted index g wins.
  - req_ready = onehot(g) & {NREQ{can_accept}}.
  - Non-granted requesters see req_ready=0 and must hold valid/data stable.
- Transfer on edge when can_accept and any req_valid:
  - resp_data <= extend(req_a[g], req_sext[g]); resp_id <= g; resp_valid <= 1; state <= FULL.
  - rr_ptr <= (g+1) mod NREQ; wraps from NREQ-1 to 0.
- Latency: 1 cycle from handshake to resp_valid.
- Drain with no new request: state FULL & resp_ready & no req_valid → resp_valid <= 0, state <= EMPTY.
  - resp_data and resp_id keep their last values.
- Stall: in FULL with resp_ready=0, resp_data and resp_id are frozen, req_ready=0, rr_ptr unchanged.
- Simultaneous drain and accept in FULL: new result replaces old in the same edge; resp_valid stays 1.
- No request in EMPTY: no state change, rr_ptr unchanged.
- rst mid-transfer: pending result is discarded, no handshake is completed, all state returns to reset values.
- Extension arithmetic:
  - sext=1: b = {{16{a[15]}}, a}.
  - sext=0: b = {16'h0000, a}.
  - Pure bit replication, no overflow case.

Optional Feature:
- Macro: EXTEND_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_cnt, 16 bits × NREQ. Per-requester counter incremented on each accepted request.
  - Counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package extend_arb_pkg:
  - state enum {EMPTY, FULL}.
  - localparam OPW=16, RESW=32.
  - function clog2 for IDW.
  - function rr_pick(req, ptr) returning the winning index and a hit flag.
- Sub-module: instantiate the team's existing extend module (a, sext, b) on the muxed winner operand, placed before the result register.
- Arbitration stays inline; no further sub-modules.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all req_valid=4'b1111 → req_ready=0, resp_valid=0, resp_data=32'h0. After release, first grant goes to requester 0.
- Mode check: req0 a=16'h8000 sext=1 → resp_data=32'hFFFF8000, resp_id=0. Next, a=16'h8000 sext=0 → 32'h00008000. Then a=16'hFFFF sext=0 → 32'h0000FFFF; a=16'h0000 sext=1 → 32'h00000000.
- Round-robin fairness: req_valid=4'b1111 held, resp_ready=1 → resp_id sequence 0,1,2,3,0, one result per cycle. Requester 2 alone after pointer=3 → grant wraps to 2.
- Back-pressure: resp_ready=0 for 5 cycles with req1 valid → resp_data stable, req_ready=0. resp_ready=1 → old result drained and req1 accepted in the same edge.
- Drain to empty: single request, then no requests, resp_ready=1 → resp_valid falls the next cycle, state EMPTY.
- Stats (macro defined): 70000 grants to req3 → grant_cnt[3]=16'hFFFF saturated, others unchanged. Apply rst → all counters 0.
